mux8_serializer: RTL and testbench

Parallel-to-serial sequencer that sits directly upstream of the 8:1 multiplexer stage. It accepts an 8-bit word over a LOAD/READY handshake and latches it into a shadow register. It then walks the 3-bit select S through all eight positions, one per clock, and presents the selected bit on Y together with VALID, LAST and DONE framing. S and the latched word drive the mux input contract directly, so a downstream mux8x1 fed with the same D and S reproduces Y.

---
 rtl/mux8_serializer.sv | 125 ++++++++++++
 tb/tb_mux8_serializer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_serializer.sv
// Parallel-to-serial sequencer feeding an 8:1 mux: latches a byte on LOAD/READY,
// then walks select S through all eight positions with VALID/LAST/DONE framing.
module mux8_serializer #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] D,
  input  logic       LOAD,
  input  logic       STALL,
  output logic       READY,
  output logic [2:0] S,
  output logic       Y,
  output logic       VALID,
  output logic       LAST,
  output logic       DONE
);

  // Stepping by 7 in 3-bit arithmetic is a decrement, so one adder serves both orders.
  localparam logic [2:0] START_IDX = MSB_FIRST ? 3'd7 : 3'd0;
  localparam logic [2:0] STEP      = MSB_FIRST ? 3'd7 : 3'd1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DONE_ST = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] shadow_q, shadow_d;
  logic [2:0] s_q, s_d;
  logic [2:0] cnt_q, cnt_d;
  logic       y_q, y_d;
  logic       valid_q, valid_d;
  logic       last_q, last_d;
  logic       done_q, done_d;
  logic       ready_q, ready_d;
  logic [2:0] s_step;

  assign s_step = s_q + STEP;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      s_q      <= START_IDX;
      cnt_q    <= '0;
      y_q      <= 1'b0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
      valid_q  <= valid_d;
      last_q   <= last_d;
      done_q   <= done_d;
      ready_q  <= ready_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    valid_d  = valid_q;
    last_d   = last_q;
    done_d   = done_q;
    ready_d  = ready_q;

    unique case (state_q)
      IDLE, DONE_ST: begin
        state_d = IDLE;
        ready_d = 1'b1;
        valid_d = 1'b0;
        last_d  = 1'b0;
        done_d  = 1'b0;
        y_d     = 1'b0;
        if (LOAD) begin
          state_d  = SHIFT;
          shadow_d = D;
          s_d      = START_IDX;
          cnt_d    = '0;
          y_d      = D[START_IDX];
          valid_d  = 1'b1;
          ready_d  = 1'b0;
        end
      end
      SHIFT: begin
        if (!STALL) begin
          s_d = s_step;
          if (cnt_q == 3'd7) begin
            // S has wrapped back to the start index, ready for the next word.
            state_d = DONE_ST;
            cnt_d   = '0;
            y_d     = 1'b0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = 1'b1;
            ready_d = 1'b1;
          end else begin
            cnt_d  = cnt_q + 3'd1;
            y_d    = shadow_q[s_step];
            last_d = (cnt_q == 3'd6);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign READY = ready_q;
  assign S     = s_q;
  assign Y     = y_q;
  assign VALID = valid_q;
  assign LAST  = last_q;
  assign DONE  = done_q;

endmodule

// File: tb/tb_mux8_serializer.sv
// Directed bench for mux8_serializer: LSB-first and MSB-first instances share stimulus;
// outputs are packed as {READY,VALID,LAST,DONE,Y,S[2:0]} and checked each cycle.
module tb_mux8_serializer;

  logic       clk = 1'b0;
  logic       rst, load, stall;
  logic [7:0] d;

  logic       rdy_l, y_l, vld_l, last_l, done_l;
  logic [2:0] s_l;
  logic       rdy_m, y_m, vld_m, last_m, done_m;
  logic [2:0] s_m;
  logic [7:0] obs_l, obs_m, exp_v;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux8_serializer u_lsb (
    .CLK(clk), .RST(rst), .D(d), .LOAD(load), .STALL(stall),
    .READY(rdy_l), .S(s_l), .Y(y_l), .VALID(vld_l), .LAST(last_l), .DONE(done_l)
  );

  mux8_serializer #(.MSB_FIRST(1'b1)) u_msb (
    .CLK(clk), .RST(rst), .D(d), .LOAD(load), .STALL(stall),
    .READY(rdy_m), .S(s_m), .Y(y_m), .VALID(vld_m), .LAST(last_m), .DONE(done_m)
  );

  assign obs_l = {rdy_l, vld_l, last_l, done_l, y_l, s_l};
  assign obs_m = {rdy_m, vld_m, last_m, done_m, y_m, s_m};

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1; load = 1'b0; stall = 1'b0; d = 8'h00;
    tick; tick;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if (obs_l !== 8'b1000_0000) begin
        n_err++;
        $display("FAIL reset_idle_lsb cyc=%0d got=%b exp=%b", i, obs_l, 8'b1000_0000);
      end
      n_cmp++;
      if (obs_m !== 8'b1000_0111) begin
        n_err++;
        $display("FAIL reset_idle_msb cyc=%0d got=%b exp=%b", i, obs_m, 8'b1000_0111);
      end
      tick;
    end
  endtask

  task automatic test_lsb_word;
    logic [0:7] seq = 8'b0110_0101;
    d = 8'hA6; load = 1'b1;
    tick;
    load = 1'b0;
    for (int n = 0; n < 8; n++) begin
      exp_v = {1'b0, 1'b1, (n == 7), 1'b0, seq[n], 3'(n)};
      n_cmp++;
      if (obs_l !== exp_v) begin
        n_err++;
        $display("FAIL lsb_bit n=%0d got=%b exp=%b", n, obs_l, exp_v);
      end
      tick;
    end
    n_cmp++;
    if (obs_l !== 8'b1001_0000) begin
      n_err++;
      $display("FAIL lsb_done got=%b exp=%b", obs_l, 8'b1001_0000);
    end
    tick;
    n_cmp++;
    if (obs_l !== 8'b1000_0000) begin
      n_err++;
      $display("FAIL lsb_idle_after got=%b exp=%b", obs_l, 8'b1000_0000);
    end
  endtask

  task automatic test_msb_first;
    logic [0:7] seq = 8'b1000_0001;
    d = 8'h81; load = 1'b1;
    tick;
    load = 1'b0;
    for (int n = 0; n < 8; n++) begin
      exp_v = {1'b0, 1'b1, (n == 7), 1'b0, seq[n], 3'(7 - n)};
      n_cmp++;
      if (obs_m !== exp_v) begin
        n_err++;
        $display("FAIL msb_bit n=%0d got=%b exp=%b", n, obs_m, exp_v);
      end
      tick;
    end
    n_cmp++;
    if (obs_m !== 8'b1001_0111) begin
      n_err++;
      $display("FAIL msb_done got=%b exp=%b", obs_m, 8'b1001_0111);
    end
    tick;
    n_cmp++;
    if (obs_m !== 8'b1000_0111) begin
      n_err++;
      $display("FAIL msb_idle_after got=%b exp=%b", obs_m, 8'b1000_0111);
    end
  endtask

  task automatic test_stall_ignore;
    // Cycles 1..11 after the load edge: S=3 held for three stalled edges.
    logic [2:0] s_tab [11] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
    logic       y_tab [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    d = 8'hF0; load = 1'b1;
    tick;
    load = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      exp_v = {1'b0, 1'b1, (c == 11), 1'b0, y_tab[c-1], s_tab[c-1]};
      n_cmp++;
      if (obs_l !== exp_v) begin
        n_err++;
        $display("FAIL stall_seq cyc=%0d got=%b exp=%b", c, obs_l, exp_v);
      end
      stall = (c >= 4 && c <= 6);
      load  = (c == 9);
      d     = (c == 9) ? 8'h00 : 8'hF0;
      tick;
    end
    stall = 1'b0; load = 1'b0;
    n_cmp++;
    if (obs_l !== 8'b1001_0000) begin
      n_err++;
      $display("FAIL stall_done_at_12 got=%b exp=%b", obs_l, 8'b1001_0000);
    end
    stall = 1'b1;
    tick;
    n_cmp++;
    if (obs_l !== 8'b1000_0000) begin
      n_err++;
      $display("FAIL stall_ignored_idle got=%b exp=%b", obs_l, 8'b1000_0000);
    end
    stall = 1'b0;
  endtask

  task automatic test_back_to_back;
    int dones = 0;
    d = 8'hFF; load = 1'b1;
    tick;
    for (int c = 1; c <= 18; c++) begin
      if (c <= 8)       exp_v = {1'b0, 1'b1, (c == 8), 1'b0, 1'b1, 3'(c - 1)};
      else if (c == 9)  exp_v = 8'b1001_0000;
      else if (c <= 17) exp_v = {1'b0, 1'b1, (c == 17), 1'b0, 1'b0, 3'(c - 10)};
      else              exp_v = 8'b1001_0000;
      n_cmp++;
      if (obs_l !== exp_v) begin
        n_err++;
        $display("FAIL b2b_seq cyc=%0d got=%b exp=%b", c, obs_l, exp_v);
      end
      if (done_l === 1'b1) dones++;
      if (c == 9)  d = 8'h00;
      if (c == 18) load = 1'b0;
      tick;
    end
    n_cmp++;
    if (dones != 2) begin
      n_err++;
      $display("FAIL b2b_done_pulses got=%0d exp=%0d", dones, 2);
    end
    n_cmp++;
    if (obs_l !== 8'b1000_0000) begin
      n_err++;
      $display("FAIL b2b_idle_after got=%b exp=%b", obs_l, 8'b1000_0000);
    end
  endtask

  task automatic test_reset_mid;
    logic [0:7] seq_a = 8'b0101_0101;
    logic [0:7] seq_5 = 8'b1010_1010;
    d = 8'hAA; load = 1'b1;
    tick;
    load = 1'b0;
    for (int n = 0; n <= 4; n++) begin
      exp_v = {1'b0, 1'b1, 1'b0, 1'b0, seq_a[n], 3'(n)};
      n_cmp++;
      if (obs_l !== exp_v) begin
        n_err++;
        $display("FAIL rmid_pre n=%0d got=%b exp=%b", n, obs_l, exp_v);
      end
      if (n == 4) rst = 1'b1;
      tick;
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (obs_l !== 8'b1000_0000) begin
        n_err++;
        $display("FAIL rmid_abort cyc=%0d got=%b exp=%b", i, obs_l, 8'b1000_0000);
      end
      tick;
    end
    d = 8'h55; load = 1'b1;
    tick;
    load = 1'b0;
    for (int n = 0; n < 8; n++) begin
      exp_v = {1'b0, 1'b1, (n == 7), 1'b0, seq_5[n], 3'(n)};
      n_cmp++;
      if (obs_l !== exp_v) begin
        n_err++;
        $display("FAIL rmid_fresh n=%0d got=%b exp=%b", n, obs_l, exp_v);
      end
      tick;
    end
    n_cmp++;
    if (obs_l !== 8'b1001_0000) begin
      n_err++;
      $display("FAIL rmid_fresh_done got=%b exp=%b", obs_l, 8'b1001_0000);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset;
    test_lsb_word;
    test_msb_first;
    test_stall_ignore;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
